full_adder: RTL and testbench
=============================

Name: full_adder

Overview:
- Full-adder cell used as the bit-slice of the datapath ripple-carry adders, e.g. 64 instances chained carry_out -> carry_in with bit 0 carry_in tied to 0.
- Combinational sum/carry paths serve the chain; optional registered copies and generate/propagate flags support pipelined and lookahead users.
- WIDTH generalises the cell to an internal ripple of WIDTH bits; WIDTH=1 is the standard bit cell.

Parameters:
- WIDTH, 1, operand width in bits (>=1); internal ripple chain of WIDTH single-bit stages.

Ports:
- clk  input  1  clock; all registers update on the rising edge.
- reset  input  1  synchronous, active-low reset; 0 at a rising clk edge clears the registers.
- en  input  1  capture enable for the registered outputs.
- A  input  WIDTH  addend.
- B  input  WIDTH  addend.
- carry_in  input  1  carry into bit 0.
- sum  output  WIDTH  combinational sum.
- carry_out  output  1  combinational carry out of the MSB.
- gen  output  1  group generate: the cell produces a carry regardless of carry_in.
- prop  output  1  group propagate: every bit of A XOR B is 1.
- sum_q  output  WIDTH  registered sum.
- carry_out_q  output  1  registered carry_out.

Behaviour:
- Per stage i: sum[i] = A[i] ^ B[i] ^ c[i]; c[i+1] = (A[i]&B[i]) | (c[i]&(A[i]^B[i])); c[0] = carry_in; carry_out = c[WIDTH].
- Equivalently {carry_out, sum} = A + B + carry_in, computed unsigned in WIDTH+1 bits with no truncation loss.
- sum, carry_out, gen and prop are purely combinational:
  - zero-cycle latency;
  - no dependence on clk, reset or en;
  - valid during and after reset.
- For WIDTH=1: gen = A&B and prop = A^B.
- For WIDTH>1, group terms:
  - prop = AND over all bits of (A^B).
  - gen = carry_out evaluated with carry_in = 0.
  - Invariant: carry_out = gen | (prop & carry_in).
- Registered path, at each rising clk edge:
  - reset == 0: sum_q <= 0, carry_out_q <= 0. Reset has priority over en.
  - else if en == 1: sum_q <= sum, carry_out_q <= carry_out.
  - else: hold.
- Reset values: sum_q = 0, carry_out_q = 0. Combinational outputs have no reset value; they track inputs.
- Registered outputs have one cycle of latency from inputs to sum_q/carry_out_q.
- Asserting reset mid-operation clears the registers at the next edge, regardless of en or inputs. The first edge with reset == 1 and en == 1 captures the current sum.
- Wrap-around: all-ones + all-ones + 1 gives sum = all-ones and carry_out = 1. No saturation and no overflow flag; signed overflow is the user's job.
- Outputs must never go X/Z for known inputs.
- No latches.
- Combinational carry depth is linear in WIDTH; ripple is acceptable.

Test Plan:
- WIDTH=1, exhaustive {A,B,carry_in} from 000 to 111 -> {carry_out,sum} = 00,01,01,10,01,10,10,11; gen = A&B; prop = A^B.
- WIDTH=1, 64 instances chained with carry_in=0:
  - A=100, B=2000 -> sum=2100, final carry=0.
  - A=5682, B=5000 -> sum=10682, final carry=0.
- WIDTH=64, A=64'hFFFF_FFFF_FFFF_FFFF, B=0, carry_in=1 -> sum=0, carry_out=1, prop=1, gen=0. Same A and B with carry_in=0 -> sum=all-ones, carry_out=0.
- WIDTH=8, A=8'hFF, B=8'hFF, carry_in=1 -> sum=8'hFF, carry_out=1, gen=1, prop=0.
- Registered path, WIDTH=8:
  - Hold reset=0 for 2 edges -> sum_q=0, carry_out_q=0.
  - Release reset, en=1, A=8'h80, B=8'h80, carry_in=0 -> after 1 edge sum_q=8'h00, carry_out_q=1.
  - Set en=0 and change inputs -> sum_q/carry_out_q hold.
- Reset priority: en=1, nonzero inputs, reset=0 at an edge -> sum_q=0, carry_out_q=0. Combinational sum is unaffected throughout.

Source files
------------

// File: rtl/full_adder.sv
// full_adder: ripple-carry adder cell, WIDTH single-bit stages.
// WIDTH=1 is the plain bit cell that gets chained carry_out -> carry_in.
//
// Ports:
//   clk          rising-edge clock for the registered copies
//   reset        synchronous, active-low; clears sum_q/carry_out_q
//   en           capture enable for sum_q/carry_out_q
//   A, B         WIDTH-bit addends
//   carry_in     carry into bit 0
//   sum          combinational sum (WIDTH bits)
//   carry_out    combinational carry out of the MSB
//   gen          group generate (carry produced with carry_in = 0)
//   prop         group propagate (every bit of A^B is 1)
//   sum_q        registered sum
//   carry_out_q  registered carry_out
module full_adder #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             carry_in,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             gen,
    output logic             prop,
    output logic [WIDTH-1:0] sum_q,
    output logic             carry_out_q
);

    logic [WIDTH:0]   carry_chain;
    // Second chain with carry_in forced to 0; its top bit is the group generate.
    logic [WIDTH:0]   gen_chain;
    logic [WIDTH-1:0] half_sum;
    logic [WIDTH-1:0] sum_d;
    logic             carry_out_d;

    always_comb begin
        carry_chain    = '0;
        gen_chain      = '0;
        half_sum       = A ^ B;
        sum            = '0;
        carry_chain[0] = carry_in;
        gen_chain[0]   = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            sum[i]           = half_sum[i] ^ carry_chain[i];
            carry_chain[i+1] = (A[i] & B[i]) | (carry_chain[i] & half_sum[i]);
            gen_chain[i+1]   = (A[i] & B[i]) | (gen_chain[i] & half_sum[i]);
        end
    end

    assign carry_out = carry_chain[WIDTH];
    assign gen       = gen_chain[WIDTH];
    assign prop      = &half_sum;

    always_comb begin
        sum_d       = sum_q;
        carry_out_d = carry_out_q;
        if (en) begin
            sum_d       = sum;
            carry_out_d = carry_out;
        end
    end

    // Reset is checked first so it wins over en.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sum_q       <= '0;
            carry_out_q <= 1'b0;
        end else begin
            sum_q       <= sum_d;
            carry_out_q <= carry_out_d;
        end
    end

endmodule

// File: tb/tb_full_adder.sv
// Directed bench for full_adder: bit cell truth table, a 64-slice chain of
// bit cells, WIDTH=64 and WIDTH=8 wrap/group cases, and the registered path.
module tb_full_adder;

    logic clk = 1'b0;
    logic reset;
    logic en;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    // WIDTH=1 cell
    logic [0:0] a1, b1, s1, sq1;
    logic       ci1, co1, g1, p1, cq1;
    full_adder #(.WIDTH(1)) u_w1 (
        .clk(clk), .reset(reset), .en(en), .A(a1), .B(b1), .carry_in(ci1),
        .sum(s1), .carry_out(co1), .gen(g1), .prop(p1),
        .sum_q(sq1), .carry_out_q(cq1));

    // 64 bit cells chained, bit 0 carry_in tied low
    logic [63:0] ch_a, ch_b, ch_s, ch_sq, ch_g, ch_p, ch_cq;
    logic [64:0] ch_c;
    assign ch_c[0] = 1'b0;
    for (genvar k = 0; k < 64; k++) begin : g_chain
        full_adder #(.WIDTH(1)) u_bit (
            .clk(clk), .reset(reset), .en(en), .A(ch_a[k:k]), .B(ch_b[k:k]),
            .carry_in(ch_c[k]), .sum(ch_s[k:k]), .carry_out(ch_c[k+1]),
            .gen(ch_g[k]), .prop(ch_p[k]), .sum_q(ch_sq[k:k]),
            .carry_out_q(ch_cq[k]));
    end

    // WIDTH=64 cell
    logic [63:0] a64, b64, s64, sq64;
    logic        ci64, co64, g64, p64, cq64;
    full_adder #(.WIDTH(64)) u_w64 (
        .clk(clk), .reset(reset), .en(en), .A(a64), .B(b64), .carry_in(ci64),
        .sum(s64), .carry_out(co64), .gen(g64), .prop(p64),
        .sum_q(sq64), .carry_out_q(cq64));

    // WIDTH=8 cell
    logic [7:0] a8, b8, s8, sq8;
    logic       ci8, co8, g8, p8, cq8;
    full_adder #(.WIDTH(8)) u_w8 (
        .clk(clk), .reset(reset), .en(en), .A(a8), .B(b8), .carry_in(ci8),
        .sum(s8), .carry_out(co8), .gen(g8), .prop(p8),
        .sum_q(sq8), .carry_out_q(cq8));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic edge_wait();
        @(posedge clk);
        #1;
    endtask

    logic [1:0] w1_tab [8];
    logic [2:0] vec;

    initial begin
        w1_tab = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
        reset = 1'b0; en = 1'b0;
        a1 = '0; b1 = '0; ci1 = 1'b0;
        ch_a = '0; ch_b = '0;
        a64 = '0; b64 = '0; ci64 = 1'b0;
        a8 = 8'h12; b8 = 8'h34; ci8 = 1'b0;

        // registered path under reset, combinational path live during reset
        edge_wait();
        edge_wait();
        chk("rst_sum_q", 64'(sq8), 64'h00);
        chk("rst_cout_q", 64'(cq8), 64'h0);
        chk("rst_comb_sum", 64'(s8), 64'h46);
        chk("rst_comb_cout", 64'(co8), 64'h0);

        // WIDTH=1 exhaustive
        for (int i = 0; i < 8; i++) begin
            vec = 3'(i);
            a1 = vec[2:2]; b1 = vec[1:1]; ci1 = vec[0];
            #1;
            chk($sformatf("w1_sum_%0d", i), 64'(s1), 64'(w1_tab[i][0]));
            chk($sformatf("w1_cout_%0d", i), 64'(co1), 64'(w1_tab[i][1]));
            chk($sformatf("w1_gen_%0d", i), 64'(g1), 64'(vec[2] & vec[1]));
            chk($sformatf("w1_prop_%0d", i), 64'(p1), 64'(vec[2] ^ vec[1]));
        end

        // 64-slice chain
        ch_a = 64'd100; ch_b = 64'd2000; #1;
        chk("chain_sum_2100", ch_s, 64'd2100);
        chk("chain_cout_2100", 64'(ch_c[64]), 64'h0);
        ch_a = 64'd5682; ch_b = 64'd5000; #1;
        chk("chain_sum_10682", ch_s, 64'd10682);
        chk("chain_cout_10682", 64'(ch_c[64]), 64'h0);
        ch_a = 64'hFFFF_FFFF_FFFF_FFFF; ch_b = 64'd1; #1;
        chk("chain_wrap_sum", ch_s, 64'h0);
        chk("chain_wrap_cout", 64'(ch_c[64]), 64'h1);

        // WIDTH=64 wrap and group terms
        a64 = 64'hFFFF_FFFF_FFFF_FFFF; b64 = 64'h0; ci64 = 1'b1; #1;
        chk("w64_sum_ci1", s64, 64'h0);
        chk("w64_cout_ci1", 64'(co64), 64'h1);
        chk("w64_prop", 64'(p64), 64'h1);
        chk("w64_gen", 64'(g64), 64'h0);
        ci64 = 1'b0; #1;
        chk("w64_sum_ci0", s64, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("w64_cout_ci0", 64'(co64), 64'h0);

        // WIDTH=8 group terms
        a8 = 8'hFF; b8 = 8'hFF; ci8 = 1'b1; #1;
        chk("w8_ff_sum", 64'(s8), 64'hFF);
        chk("w8_ff_cout", 64'(co8), 64'h1);
        chk("w8_ff_gen", 64'(g8), 64'h1);
        chk("w8_ff_prop", 64'(p8), 64'h0);
        a8 = 8'h0F; b8 = 8'hF0; ci8 = 1'b0; #1;
        chk("w8_prop_sum", 64'(s8), 64'hFF);
        chk("w8_prop_cout", 64'(co8), 64'h0);
        chk("w8_prop_prop", 64'(p8), 64'h1);
        chk("w8_prop_gen", 64'(g8), 64'h0);
        ci8 = 1'b1; #1;
        chk("w8_prop_ci1_sum", 64'(s8), 64'h00);
        chk("w8_prop_ci1_cout", 64'(co8), 64'h1);

        // registered capture
        reset = 1'b1; en = 1'b1;
        a8 = 8'h80; b8 = 8'h80; ci8 = 1'b0;
        edge_wait();
        chk("cap_sum_q", 64'(sq8), 64'h00);
        chk("cap_cout_q", 64'(cq8), 64'h1);

        // hold with en low
        en = 1'b0; a8 = 8'h01; b8 = 8'h02;
        edge_wait();
        chk("hold_sum_q", 64'(sq8), 64'h00);
        chk("hold_cout_q", 64'(cq8), 64'h1);
        chk("hold_comb_sum", 64'(s8), 64'h03);
        edge_wait();
        chk("hold2_cout_q", 64'(cq8), 64'h1);

        en = 1'b1;
        edge_wait();
        chk("recap_sum_q", 64'(sq8), 64'h03);
        chk("recap_cout_q", 64'(cq8), 64'h0);

        a8 = 8'hF0; b8 = 8'h20; ci8 = 1'b1;
        edge_wait();
        chk("cap2_sum_q", 64'(sq8), 64'h11);
        chk("cap2_cout_q", 64'(cq8), 64'h1);

        // reset beats en
        reset = 1'b0;
        edge_wait();
        chk("prio_sum_q", 64'(sq8), 64'h00);
        chk("prio_cout_q", 64'(cq8), 64'h0);
        chk("prio_comb_sum", 64'(s8), 64'h11);
        chk("prio_comb_cout", 64'(co8), 64'h1);

        // first edge out of reset captures the live sum
        reset = 1'b1;
        edge_wait();
        chk("post_rst_sum_q", 64'(sq8), 64'h11);
        chk("post_rst_cout_q", 64'(cq8), 64'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
